uart_baud_tick_gen: RTL and testbench
=====================================

// Module: uart_baud_tick_gen
// PURPOSE
//  Programmable UART baud-tick generator; next generation of the fixed toggle-clock divider.
//  Emits single-cycle clock enables, not derived clocks: rx_tick at BAUD*RX_OVERSAMPLE, tx_tick at BAUD.
//  Divisor is runtime-loadable (integer + optional fractional part) via a valid/ready handshake.
//  Sits between the system clock domain and the UART TX/RX engines; all logic on clk.
// PARAMETERS
//  CLK_RATE       25000000  system clock frequency, Hz
//  BAUD_RATE      115200    reset-time baud rate
//  RX_OVERSAMPLE  16        rx_ticks per tx_tick; >=2
//  DIV_W          16        integer divisor width
//  FRAC_W         4         fractional divisor width (1/2^FRAC_W steps)
//  Reset divisor D0 = floor(CLK_RATE*2^FRAC_W/(BAUD_RATE*RX_OVERSAMPLE)); defaults -> 217 = int 13, frac 9
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       synchronous, active-low reset
//  enable        in   1       1 = generate ticks; 0 = hold phase at zero
//  cfg_div_int   in   DIV_W   new integer divisor (clk cycles per rx_tick)
//  cfg_div_frac  in   FRAC_W  new fractional divisor
//  cfg_valid     in   1       config request
//  cfg_ready     out  1       config slot free
//  cfg_err       out  1       1-cycle pulse: requested div_int < 2, clamped to 2
//  rx_tick       out  1       1-cycle enable at oversample rate
//  tx_tick       out  1       1-cycle enable at baud rate
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk): cnt=0, frac_acc=0, os_cnt=0, active div=D0, pending cleared,
//   rx_tick=0, tx_tick=0, cfg_err=0, cfg_ready=1. Synchronous; pending config discarded.
//  Rx period: N = div_int + carry; carry = (frac_acc + div_frac >= 2^FRAC_W), evaluated once per period;
//   frac_acc <= (frac_acc + div_frac) mod 2^FRAC_W at each period end. cnt runs 0..N-1, wraps to 0.
//  rx_tick registered: high exactly 1 cycle per period; first rx_tick N cycles after enable first sampled 1.
//  os_cnt increments on rx_tick, wraps RX_OVERSAMPLE-1 -> 0; tx_tick asserted in the same cycle as the
//   rx_tick that wraps os_cnt (every RX_OVERSAMPLE-th rx_tick, coincident with it).
//  enable=0: next cycle cnt, frac_acc, os_cnt =0, ticks=0; active div retained.
//  Handshake: transfer when cfg_valid & cfg_ready; values captured into pending, cfg_ready <=0.
//   Pending applied at next period boundary (cycle rx_tick asserts), or next cycle if enable=0.
//   Applying cycle resets frac_acc and os_cnt; cfg_ready <=1 the cycle after apply.
//   Transfer in the same cycle as a boundary: applied at the following boundary, not this one.
//   cfg_div_int <2 -> stored as 2 (min period 2 clk), cfg_err pulses 1 cycle at capture.
//  Width: cnt DIV_W bits; N max 2^DIV_W (div_int all-ones + carry) fits count 0..2^DIV_W-1. No overflow.
// CONFIGURATION
//  UART_BAUD_FRAC_EN defined: fractional accumulator as above.
//  Not defined: cfg_div_frac ignored, carry=0, frac_acc removed; reset div = D0>>FRAC_W (13 at defaults).
// STRUCTURE
//  Package uart_baud_pkg: DIV_W/FRAC_W defaults, div_t struct {int, frac}, function calc_div0().
//  Sub-module uart_baud_frac_div: cnt + frac_acc, outputs period-end strobe; top adds os_cnt and cfg handshake.
// TESTING
//  1 Reset, enable=1, defaults, FRAC_EN: rx periods 13/14 mixed, 9 of 14 per 16; tx_tick every 217 clk exactly.
//  2 cfg int=4 frac=0 mid-period: old period completes, then rx_tick every 4 clk, tx_tick every 64; cfg_ready back.
//  3 cfg int=1: cfg_err 1-cycle pulse, period becomes 2 clk, tx_tick every 32 clk.
//  4 enable 1->0 mid-period: ticks 0 next cycle; re-enable -> first rx_tick after exactly N clk, os_cnt from 0.
//  5 reset_n=0 for 1 cycle with pending cfg: D0 restored, cfg_ready=1, pending dropped, ticks restart from phase 0.
//  6 Macro undefined: cfg_div_frac=15 ignored; rx_tick every 13 clk, tx_tick every 208 clk.

Source files
------------

// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg
//   Shared constants and helpers for the UART baud-tick generator.
//   DIV_W_DEF / FRAC_W_DEF : default integer / fractional divisor widths
//   div_t                  : divisor pair {integer, fractional} at default widths
//   calc_div0()            : reset-time divisor in 1/2^frac_w units
package uart_baud_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } div_t;

  // floor(clk_rate * 2^frac_w / (baud_rate * oversample)); upper bits hold
  // the integer divisor, the low frac_w bits the fractional part.
  function automatic longint unsigned calc_div0(input longint unsigned clk_rate,
                                                input longint unsigned baud_rate,
                                                input longint unsigned oversample,
                                                input int unsigned     frac_w);
    return (clk_rate << frac_w) / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_frac_div.sv
// uart_baud_frac_div
//   Period counter for the rx oversample tick. Counts cnt 0..N-1 with
//   N = div_int (+1 when the fractional accumulator carries) and flags the
//   last cycle of each period on period_end (combinational).
//   Fractional accumulator present only when UART_BAUD_FRAC_EN is defined.
// Ports
//   clk, reset_n : system clock, synchronous active-low reset
//   run          : 0 clears the phase (cnt and accumulator)
//   restart      : clear the accumulator at this period end (new divisor applied)
//   div_int      : active integer divisor (>= 2)
//   div_frac     : active fractional divisor
//   period_end   : high in the last cycle of the current period
module uart_baud_frac_div
  import uart_baud_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
`ifdef UART_BAUD_FRAC_EN
  , parameter int FRAC_W = FRAC_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
`ifdef UART_BAUD_FRAC_EN
  input  logic             restart,
  input  logic [FRAC_W-1:0] div_frac,
`endif
  input  logic [DIV_W-1:0] div_int,
  output logic             period_end
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;
  logic              carry;

  // Carry depends only on acc_q, which moves at period ends, so it is
  // constant for the whole period.
  assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac};
  assign carry   = acc_sum[FRAC_W];
  // div_int >= 2, so N-1 always fits in DIV_W bits even at all-ones + carry.
  assign last    = div_int - DIV_W'(1) + DIV_W'(carry);
`else
  assign last    = div_int - DIV_W'(1);
`endif

  assign period_end = run && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (!run || period_end) cnt_d = '0;
    else                    cnt_d = cnt_q + DIV_W'(1);
  end

`ifdef UART_BAUD_FRAC_EN
  always_comb begin
    acc_d = acc_q;
    if (!run || (period_end && restart)) acc_d = '0;
    else if (period_end)                 acc_d = acc_sum[FRAC_W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
`ifdef UART_BAUD_FRAC_EN
      acc_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
`ifdef UART_BAUD_FRAC_EN
      acc_q <= acc_d;
`endif
    end
  end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen
//   Programmable UART baud-tick generator. Emits single-cycle enables:
//   rx_tick at BAUD*RX_OVERSAMPLE, tx_tick on every RX_OVERSAMPLE-th rx_tick.
//   Divisor is loaded at runtime through a valid/ready handshake and takes
//   effect at the next rx period boundary (or next cycle while disabled).
//   Macro UART_BAUD_FRAC_EN enables the fractional divisor; without it
//   cfg_div_frac is ignored and the reset divisor is D0 >> FRAC_W.
// Ports
//   clk, reset_n             : system clock, synchronous active-low reset
//   enable                   : 1 = generate ticks, 0 = hold phase at zero
//   cfg_div_int/cfg_div_frac : requested divisor
//   cfg_valid / cfg_ready    : config handshake
//   cfg_err                  : 1-cycle pulse when div_int < 2 was clamped to 2
//   rx_tick / tx_tick        : oversample / baud clock enables
module uart_baud_tick_gen
  import uart_baud_pkg::*;
#(
  parameter int CLK_RATE      = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_OVERSAMPLE = 16,
  parameter int DIV_W         = DIV_W_DEF,
  parameter int FRAC_W        = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              rx_tick,
  output logic              tx_tick
);

  localparam logic [63:0] D0 = 64'(calc_div0(64'(CLK_RATE), 64'(BAUD_RATE),
                                             64'(RX_OVERSAMPLE), FRAC_W));
  localparam logic [DIV_W-1:0] D0_INT = D0[FRAC_W +: DIV_W];
  localparam int OS_W = (RX_OVERSAMPLE > 2) ? $clog2(RX_OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(RX_OVERSAMPLE - 1);

  logic [DIV_W-1:0] div_int_q, div_int_d, pend_int_q, pend_int_d;
`ifdef UART_BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] D0_FRAC = D0[FRAC_W-1:0];
  logic [FRAC_W-1:0] div_frac_q, div_frac_d, pend_frac_q, pend_frac_d;
`else
  logic unused_cfg_frac;
  assign unused_cfg_frac = ^cfg_div_frac;
`endif
  logic            pend_vld_q, pend_vld_d;
  logic            ready_q, ready_d;
  logic            apply_q, apply_d;
  logic            err_q, err_d;
  logic            rx_q, rx_d, tx_q, tx_d;
  logic [OS_W-1:0] os_q, os_d;

  logic xfer, apply, period_end, clamp;

  assign xfer  = cfg_valid && ready_q;
  assign clamp = (cfg_div_int < DIV_W'(2));
  // A transfer on a boundary edge sees pend_vld_q=0, so it waits for the next boundary.
  assign apply = pend_vld_q && (period_end || !enable);

  uart_baud_frac_div #(
    .DIV_W (DIV_W)
`ifdef UART_BAUD_FRAC_EN
    , .FRAC_W(FRAC_W)
`endif
  ) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (enable),
`ifdef UART_BAUD_FRAC_EN
    .restart    (apply),
    .div_frac   (div_frac_q),
`endif
    .div_int    (div_int_q),
    .period_end (period_end)
  );

  always_comb begin
    div_int_d  = div_int_q;
    pend_int_d = pend_int_q;
`ifdef UART_BAUD_FRAC_EN
    div_frac_d  = div_frac_q;
    pend_frac_d = pend_frac_q;
`endif
    pend_vld_d = pend_vld_q;
    ready_d    = ready_q;
    apply_d    = apply;
    err_d      = xfer && clamp;
    rx_d       = period_end;
    tx_d       = period_end && (os_q == OS_LAST);
    os_d       = os_q;

    if (xfer) begin
      pend_int_d = clamp ? DIV_W'(2) : cfg_div_int;
`ifdef UART_BAUD_FRAC_EN
      pend_frac_d = cfg_div_frac;
`endif
      pend_vld_d = 1'b1;
      ready_d    = 1'b0;
    end
    if (apply) begin
      div_int_d  = pend_int_q;
`ifdef UART_BAUD_FRAC_EN
      div_frac_d = pend_frac_q;
`endif
      pend_vld_d = 1'b0;
    end
    if (apply_q) ready_d = 1'b1;

    if (!enable || apply)  os_d = '0;
    else if (period_end)   os_d = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_int_q  <= D0_INT;
      pend_int_q <= '0;
`ifdef UART_BAUD_FRAC_EN
      div_frac_q  <= D0_FRAC;
      pend_frac_q <= '0;
`endif
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      apply_q    <= 1'b0;
      err_q      <= 1'b0;
      rx_q       <= 1'b0;
      tx_q       <= 1'b0;
      os_q       <= '0;
    end else begin
      div_int_q  <= div_int_d;
      pend_int_q <= pend_int_d;
`ifdef UART_BAUD_FRAC_EN
      div_frac_q  <= div_frac_d;
      pend_frac_q <= pend_frac_d;
`endif
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      apply_q    <= apply_d;
      err_q      <= err_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      os_q       <= os_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign rx_tick   = rx_q;
  assign tx_tick   = tx_q;

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Testbench for uart_baud_tick_gen. Stimulus pushes the absolute cycle at
// which each rx_tick / tx_tick / cfg_err pulse is due; a monitor pops and
// compares whenever the DUT raises one of them.
module tb_uart_baud_tick_gen;

`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_EN = 1'b1;
`else
  localparam bit FRAC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] cfg_div_int = '0;
  logic [3:0]  cfg_div_frac = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready, cfg_err, rx_tick, tx_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rx_q[$];
  int tx_q[$];
  int err_q[$];

  uart_baud_tick_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .rx_tick      (rx_tick),
    .tx_tick      (tx_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every asserted output must match the head of its queue.
  task automatic pop_chk(input string name, inout int q[$]);
    int e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected pulse at cyc %0d, none expected", name, cyc);
    end else begin
      e = q.pop_front();
      chk(name, cyc, e);
    end
  endtask

  always @(negedge clk) begin
    if (rx_tick) pop_chk("rx_tick time", rx_q);
    if (tx_tick) pop_chk("tx_tick time", tx_q);
    if (cfg_err) pop_chk("cfg_err time", err_q);
  end

  task automatic tick_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Expected ticks for a run starting with phase at zero: enable (or the
  // apply boundary) at cycle t0, accumulator and os_cnt at zero.
  task automatic push_run(input int t0, input int dint, input int dfrac, input int nrx);
    int t, acc, n;
    t = t0;
    acc = 0;
    for (int i = 1; i <= nrx; i++) begin
      n = dint;
      if (FRAC_EN && (acc + dfrac >= 16)) n++;
      if (FRAC_EN) acc = (acc + dfrac) % 16;
      t += n;
      rx_q.push_back(t);
      if (i % 16 == 0) tx_q.push_back(t);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((rx_q.size() + tx_q.size() + err_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, rx_q.size() + tx_q.size() + err_q.size(), 0);
    rx_q.delete();
    tx_q.delete();
    err_q.delete();
  endtask

  // Config transfer while disabled; returns once cfg_ready is back.
  task automatic cfg_idle(input int di, input int df);
    cfg_div_int  = 16'(di);
    cfg_div_frac = 4'(df);
    cfg_valid    = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cfg_ready after idle apply", cfg_ready, 1);
  endtask

  initial begin
    int e, c, r, t2;
    repeat (3) @(negedge clk);
    chk("reset rx_tick", rx_tick, 0);
    chk("reset tx_tick", tx_tick, 0);
    chk("reset cfg_ready", cfg_ready, 1);
    chk("reset cfg_err", cfg_err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: default divisor 13 (+9/16 with fraction): tx every 217 or 208 clk
    e = cyc;
    enable = 1'b1;
    push_run(e, 13, 9, 48);
    drain("t1 drain", 800);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // 2: load 4/0 mid-period; old 13-cycle period completes first
    e = cyc;
    enable = 1'b1;
    rx_q.push_back(e + 13);
    push_run(e + 13, 4, 0, 32);
    tick_to(e + 5);
    cfg_div_int = 16'd4; cfg_div_frac = 4'd0; cfg_valid = 1'b1;
    tick_to(e + 6);
    cfg_valid = 1'b0;
    chk("t2 cfg_ready after capture", cfg_ready, 0);
    chk("t2 cfg_err quiet", cfg_err, 0);
    tick_to(e + 13);
    chk("t2 cfg_ready at apply", cfg_ready, 0);
    tick_to(e + 14);
    chk("t2 cfg_ready after apply", cfg_ready, 1);
    drain("t2 drain", 400);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // 3: div_int=1 clamps to 2, cfg_err pulses once
    c = cyc;
    err_q.push_back(c + 1);
    cfg_div_int = 16'd1; cfg_div_frac = 4'd0; cfg_valid = 1'b1;
    tick_to(c + 1);
    cfg_valid = 1'b0;
    chk("t3 cfg_err high", cfg_err, 1);
    chk("t3 cfg_ready low", cfg_ready, 0);
    tick_to(c + 2);
    chk("t3 cfg_err one cycle", cfg_err, 0);
    tick_to(c + 3);
    chk("t3 cfg_ready back", cfg_ready, 1);
    e = cyc;
    enable = 1'b1;
    push_run(e, 2, 0, 48);
    drain("t3 drain", 200);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // 4: disable mid-period, re-enable restarts phase and os_cnt
    cfg_idle(10, 0);
    e = cyc;
    enable = 1'b1;
    rx_q.push_back(e + 10);
    rx_q.push_back(e + 20);
    tick_to(e + 25);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4 ticks while disabled", {30'd0, rx_tick, tx_tick}, 0);
    end
    r = cyc;
    enable = 1'b1;
    push_run(r, 10, 0, 16);
    drain("t4 drain", 300);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // 5: reset with a pending config drops it and restores D0
    e = cyc;
    enable = 1'b1;
    tick_to(e + 3);
    cfg_div_int = 16'd6; cfg_div_frac = 4'd0; cfg_valid = 1'b1;
    tick_to(e + 4);
    cfg_valid = 1'b0;
    chk("t5 cfg_ready pending", cfg_ready, 0);
    tick_to(e + 5);
    reset_n = 1'b0;
    tick_to(e + 6);
    reset_n = 1'b1;
    chk("t5 cfg_ready after reset", cfg_ready, 1);
    chk("t5 rx_tick after reset", rx_tick, 0);
    push_run(e + 6, 13, 9, 32);
    drain("t5 drain", 600);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // 6: fraction 15 (ignored without the fractional feature)
    cfg_idle(13, 15);
    e = cyc;
    enable = 1'b1;
    push_run(e, 13, 15, 32);
    drain("t6 drain", 600);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // 7: transfer on a boundary edge applies at the following boundary
    e = cyc;
    enable = 1'b1;
    t2 = e + 13 + (FRAC_EN ? 14 : 13);
    rx_q.push_back(e + 13);
    rx_q.push_back(t2);
    push_run(t2, 5, 0, 16);
    tick_to(e + 12);
    cfg_div_int = 16'd5; cfg_div_frac = 4'd0; cfg_valid = 1'b1;
    tick_to(e + 13);
    cfg_valid = 1'b0;
    chk("t7 cfg_ready after boundary capture", cfg_ready, 0);
    drain("t7 drain", 300);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
